// File: rtl/seq_divider.sv
// Sequential restoring divider, signed/unsigned, one quotient bit per clock.
// Latency: done pulses WIDTH+1 edges after acceptance (divide-by-zero: next cycle).
// Backpressure: ready low while iterating; start accepted in IDLE or DONE (back-to-back).
`timescale 1ns/1ps
module seq_divider #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             fin_q;        // all WIDTH iterations have been applied
  logic [WIDTH-1:0] dvd_q;        // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs_q;        // divisor magnitude
  logic [WIDTH-1:0] quo_q;        // quotient magnitude being built
  logic [WIDTH-1:0] part_q;       // partial remainder
  logic             q_neg_q;
  logic             r_neg_q;
  logic             ready_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             accept_d;
  logic             signed_mode_d;
  logic             dvd_neg_d;
  logic             dvs_neg_d;
  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic [WIDTH:0]   shift_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] part_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_fix_d;
  logic [WIDTH-1:0] r_fix_d;

  // Operand magnitudes, one restoring step, and final sign correction.
  always_comb begin
    accept_d      = start && ready_q;
    signed_mode_d = (SIGNED_EN != 0) && signed_op;
    dvd_neg_d     = signed_mode_d && dividend[WIDTH-1];
    dvs_neg_d     = signed_mode_d && divisor[WIDTH-1];
    dvd_mag_d     = dvd_neg_d ? (~dividend + WIDTH'(1)) : dividend;
    dvs_mag_d     = dvs_neg_d ? (~divisor + WIDTH'(1)) : divisor;

    // Partial remainder is always below the divisor, so the difference
    // fits in WIDTH+1 bits and its MSB is a reliable sign.
    shift_d = {part_q, dvd_q[WIDTH-1]};
    trial_d = shift_d - {1'b0, dvs_q};
    if (trial_d[WIDTH]) begin
      part_d = shift_d[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      part_d = trial_d[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], 1'b1};
    end

    // MIN / -1 yields magnitude MIN with positive sign, which wraps to MIN.
    q_fix_d = q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
    r_fix_d = r_neg_q ? (~part_q + WIDTH'(1)) : part_q;
  end

  // Control FSM, datapath state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      part_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
          if (accept_d) begin
            dvd_q   <= dvd_mag_d;
            dvs_q   <= dvs_mag_d;
            quo_q   <= '0;
            part_q  <= '0;
            q_neg_q <= dvd_neg_d ^ dvs_neg_d;
            r_neg_q <= dvd_neg_d;
            cnt_q   <= CW'(WIDTH - 1);
            fin_q   <= 1'b0;
            if (divisor == '0) begin
              // Nothing to iterate: report immediately with the raw dividend.
              state_q     <= DONE;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
            end else begin
              state_q <= CALC;
              ready_q <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!fin_q) begin
            dvd_q  <= dvd_q << 1;
            part_q <= part_d;
            quo_q  <= quo_d;
            if (cnt_q == '0) begin
              fin_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end else begin
            state_q     <= DONE;
            ready_q     <= 1'b1;
            done_q      <= 1'b1;
            dbz_q       <= 1'b0;
            quotient_q  <= q_fix_d;
            remainder_q <= r_fix_d;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Parameter SIGNED_EN, default 1; when 0 the signed_op input SHALL be ignored and every division SHALL be unsigned.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request a division; sampled only while ready=1.
REQ-006 ready  output  1  block can accept start this cycle.
REQ-007 dividend  input  WIDTH  numerator; sampled on the accepting edge.
REQ-008 divisor  input  WIDTH  denominator; sampled on the accepting edge.
REQ-009 signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the accepting edge.
REQ-010 done  output  1  one-cycle pulse; results valid.
REQ-011 quotient  output  WIDTH  registered quotient.
REQ-012 remainder  output  WIDTH  registered remainder.
REQ-013 div_by_zero  output  1  registered; set with done when the divisor was 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 ready SHALL be 1 in IDLE and in DONE, and 0 in CALC.
REQ-016 Accept: start=1 and ready=1 on an edge SHALL latch the operands and signed_op, and SHALL enter CALC with the iteration counter at WIDTH-1.
REQ-017 Operand prep: in signed mode both operands SHALL be converted to magnitudes (WIDTH bits, unsigned), and the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign) SHALL be recorded.
REQ-018 CALC, per edge: shift the partial remainder left by one, bringing in the next magnitude-dividend bit, MSB first.
REQ-019 CALC, per edge: perform a WIDTH+1-bit trial subtraction of the divisor magnitude.
REQ-020 CALC, per edge: if the trial result is non-negative, keep it and set the quotient bit to 1; otherwise keep the unsubtracted partial and set the quotient bit to 0 (restoring algorithm).
REQ-021 After WIDTH iterations the FSM SHALL go to DONE.
REQ-022 On the transition into DONE: apply sign correction (negate the quotient and/or remainder per REQ-017), register quotient, remainder and div_by_zero, and assert done.
REQ-023 Latency: done SHALL be high in the cycle following the (WIDTH+1)-th edge after the accepting edge.
REQ-024 done SHALL be high for exactly one cycle.
REQ-025 DONE SHALL go to IDLE on the next edge; if start=1 on that edge, it SHALL instead accept the new operation and go to CALC (back-to-back, no bubble).
REQ-026 Signed results SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-027 Overflow (signed MIN / -1) SHALL produce quotient = MIN and remainder = 0, with no flag.
REQ-028 Divisor = 0: the FSM SHALL skip CALC and go from the accepting edge straight to DONE.
REQ-029 Divisor = 0: the FSM SHALL register quotient = all ones, remainder = the raw dividend, and div_by_zero = 1, with done high in the cycle after the accepting edge.
REQ-030 div_by_zero SHALL be 0 for every other result, and SHALL be updated only together with done.
REQ-031 start while ready=0 SHALL be ignored; operand changes during CALC SHALL NOT affect the result in progress.
REQ-032 quotient, remainder and div_by_zero SHALL hold their values from done until the next done.

Reset
REQ-033 rst=1 on an edge SHALL force IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and partial state.
REQ-034 Reset SHALL take priority over start and over any operation in progress; a division aborted by reset SHALL NOT produce done.
REQ-035 The first start after rst is released SHALL be accepted normally.

Verification (WIDTH=8, SIGNED_EN=1)
REQ-036 Unsigned 200/7 -> done exactly 9 cycles after the accepting edge; quotient=28 (0x1C), remainder=4, div_by_zero=0.
REQ-037 Signed -7/2 -> quotient=0xFD (-3), remainder=0xFF (-1); signed 7/-2 -> quotient=0xFD, remainder=0x01.
REQ-038 Signed -128/-1 -> quotient=0x80, remainder=0x00, div_by_zero=0.
REQ-039 13/0 (either mode) -> done in the cycle after acceptance; quotient=0xFF, remainder=0x0D, div_by_zero=1.
REQ-040 Back-to-back: start held during DONE of 200/7 with new operands 9/3 -> second done 9 cycles later, quotient=3, remainder=0; start pulses during CALC are ignored.
REQ-041 Reset mid-operation: assert rst at iteration 4 of 100/3 -> next cycle ready=1, done=0, outputs 0; then 100/3 completes with quotient=33, remainder=1.
